// File: rtl/ex_stage_if.sv
// Execute-stage bus: the decode->EX offer, the EX->MEM result and the
// bypass view that EX exposes back to decode.
interface ex_stage_if #(
    parameter int DATA_W   = 32,
    parameter int ALU_OP_W = 12
);
    // decode -> EX
    logic                ds_to_es_valid;
    logic                es_allowin;
    logic [DATA_W-1:0]   ds_to_es_pc;
    logic [ALU_OP_W-1:0] ds_to_es_alu_op;
    logic                ds_to_es_src1_is_sa;
    logic                ds_to_es_src1_is_pc;
    logic                ds_to_es_src2_is_imm;
    logic                ds_to_es_src2_is_8;
    logic                ds_to_es_imm_zext;
    logic [15:0]         ds_to_es_imm;
    logic [DATA_W-1:0]   ds_to_es_rs_value;
    logic [DATA_W-1:0]   ds_to_es_rt_value;
    logic [4:0]          ds_to_es_dest;
    logic                ds_to_es_gr_we;
    logic                ds_to_es_mem_we;
    logic                ds_to_es_res_from_mem;

    // EX -> MEM
    logic                ms_allowin;
    logic                es_to_ms_valid;
    logic [DATA_W-1:0]   es_to_ms_pc;
    logic [DATA_W-1:0]   es_to_ms_alu_result;
    logic [DATA_W-1:0]   es_to_ms_store_data;
    logic [4:0]          es_to_ms_dest;
    logic                es_to_ms_gr_we;
    logic                es_to_ms_mem_we;
    logic                es_to_ms_res_from_mem;

    // EX -> decode bypass
    logic                es_fwd_valid;
    logic [4:0]          es_fwd_dest;
    logic [DATA_W-1:0]   es_fwd_data;
    logic                es_fwd_is_load;

    // neighbouring stages' view
    modport master (
        output ds_to_es_valid, ds_to_es_pc, ds_to_es_alu_op,
               ds_to_es_src1_is_sa, ds_to_es_src1_is_pc,
               ds_to_es_src2_is_imm, ds_to_es_src2_is_8, ds_to_es_imm_zext,
               ds_to_es_imm, ds_to_es_rs_value, ds_to_es_rt_value,
               ds_to_es_dest, ds_to_es_gr_we, ds_to_es_mem_we,
               ds_to_es_res_from_mem, ms_allowin,
        input  es_allowin, es_to_ms_valid, es_to_ms_pc, es_to_ms_alu_result,
               es_to_ms_store_data, es_to_ms_dest, es_to_ms_gr_we,
               es_to_ms_mem_we, es_to_ms_res_from_mem,
               es_fwd_valid, es_fwd_dest, es_fwd_data, es_fwd_is_load
    );

    // execute stage's view
    modport slave (
        input  ds_to_es_valid, ds_to_es_pc, ds_to_es_alu_op,
               ds_to_es_src1_is_sa, ds_to_es_src1_is_pc,
               ds_to_es_src2_is_imm, ds_to_es_src2_is_8, ds_to_es_imm_zext,
               ds_to_es_imm, ds_to_es_rs_value, ds_to_es_rt_value,
               ds_to_es_dest, ds_to_es_gr_we, ds_to_es_mem_we,
               ds_to_es_res_from_mem, ms_allowin,
        output es_allowin, es_to_ms_valid, es_to_ms_pc, es_to_ms_alu_result,
               es_to_ms_store_data, es_to_ms_dest, es_to_ms_gr_we,
               es_to_ms_mem_we, es_to_ms_res_from_mem,
               es_fwd_valid, es_fwd_dest, es_fwd_data, es_fwd_is_load
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register with valid/allowin handshake, operand
// selection, single-cycle one-hot ALU, result bundle to MEM and bypass
// view back to decode.
module ex_stage #(
    parameter int ALU_OP_W = 12,   // tied to the ALU's one-hot encoding; keep at 12
    parameter int DATA_W   = 32
) (
    input  logic      clk,
    input  logic      resetn,
    input  logic      flush,
    ex_stage_if.slave es_bus
);
    localparam int SH_W = $clog2(DATA_W);

    // one-hot ALU control bit positions
    localparam int OP_ADD  = 11;
    localparam int OP_SUB  = 10;
    localparam int OP_SLT  = 9;
    localparam int OP_SLTU = 8;
    localparam int OP_AND  = 7;
    localparam int OP_NOR  = 6;
    localparam int OP_OR   = 5;
    localparam int OP_XOR  = 4;
    localparam int OP_SLL  = 3;
    localparam int OP_SRL  = 2;
    localparam int OP_SRA  = 1;
    localparam int OP_LUI  = 0;

    logic                vld_p1;
    logic [DATA_W-1:0]   pc_p1;
    logic [ALU_OP_W-1:0] alu_op_p1;
    logic                src1_is_sa_p1;
    logic                src1_is_pc_p1;
    logic                src2_is_imm_p1;
    logic                src2_is_8_p1;
    logic                imm_zext_p1;
    logic [15:0]         imm_p1;
    logic [DATA_W-1:0]   rs_value_p1;
    logic [DATA_W-1:0]   rt_value_p1;
    logic [4:0]          dest_p1;
    logic                gr_we_p1;
    logic                mem_we_p1;
    logic                res_from_mem_p1;

    logic                es_ready_go;
    logic                es_allowin;
    logic                load_p1;
    logic [DATA_W-1:0]   imm_ext;
    logic [DATA_W-1:0]   src1;
    logic [DATA_W-1:0]   src2;
    logic [DATA_W-1:0]   alu_result;

    // One-hot ALU: every selected term is OR-ed in, so an all-zero
    // control yields zero. Shifts move src2 by src1; lui places src2's
    // low half in the upper half. Arithmetic wraps, no overflow trap.
    function automatic logic [DATA_W-1:0] alu_calc(
        input logic [ALU_OP_W-1:0] op,
        input logic [DATA_W-1:0]   a,
        input logic [DATA_W-1:0]   b
    );
        logic signed [DATA_W-1:0] a_s;
        logic signed [DATA_W-1:0] b_s;
        logic signed [DATA_W-1:0] sra_r;
        logic [SH_W-1:0]          sh;
        logic [DATA_W-1:0]        r;
        a_s   = a;
        b_s   = b;
        sh    = a[SH_W-1:0];
        sra_r = b_s >>> sh;
        r     = '0;
        if (op[OP_ADD])  r = r | (a + b);
        if (op[OP_SUB])  r = r | (a - b);
        if (op[OP_SLT])  r = r | {{(DATA_W-1){1'b0}}, (a_s < b_s)};
        if (op[OP_SLTU]) r = r | {{(DATA_W-1){1'b0}}, (a < b)};
        if (op[OP_AND])  r = r | (a & b);
        if (op[OP_NOR])  r = r | ~(a | b);
        if (op[OP_OR])   r = r | (a | b);
        if (op[OP_XOR])  r = r | (a ^ b);
        if (op[OP_SLL])  r = r | (b << sh);
        if (op[OP_SRL])  r = r | (b >> sh);
        if (op[OP_SRA])  r = r | sra_r;
        if (op[OP_LUI])  r = r | {b[15:0], {(DATA_W-16){1'b0}}};
        return r;
    endfunction

    // single-cycle ALU never stalls EX
    assign es_ready_go = 1'b1;
    assign es_allowin  = !vld_p1 | (es_ready_go & es_bus.ms_allowin);
    assign load_p1     = es_bus.ds_to_es_valid & es_allowin & ~flush;

    // ---- stage p1: ID/EX register ----
    // Valid bit: flush kills the held instruction and beats a new offer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (es_allowin) begin
            vld_p1 <= es_bus.ds_to_es_valid;
        end
    end

    // Bundle: loads only on an accepted offer, so outputs hold under backpressure.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_p1           <= '0;
            alu_op_p1       <= '0;
            src1_is_sa_p1   <= 1'b0;
            src1_is_pc_p1   <= 1'b0;
            src2_is_imm_p1  <= 1'b0;
            src2_is_8_p1    <= 1'b0;
            imm_zext_p1     <= 1'b0;
            imm_p1          <= '0;
            rs_value_p1     <= '0;
            rt_value_p1     <= '0;
            dest_p1         <= '0;
            gr_we_p1        <= 1'b0;
            mem_we_p1       <= 1'b0;
            res_from_mem_p1 <= 1'b0;
        end else if (load_p1) begin
            pc_p1           <= es_bus.ds_to_es_pc;
            alu_op_p1       <= es_bus.ds_to_es_alu_op;
            src1_is_sa_p1   <= es_bus.ds_to_es_src1_is_sa;
            src1_is_pc_p1   <= es_bus.ds_to_es_src1_is_pc;
            src2_is_imm_p1  <= es_bus.ds_to_es_src2_is_imm;
            src2_is_8_p1    <= es_bus.ds_to_es_src2_is_8;
            imm_zext_p1     <= es_bus.ds_to_es_imm_zext;
            imm_p1          <= es_bus.ds_to_es_imm;
            rs_value_p1     <= es_bus.ds_to_es_rs_value;
            rt_value_p1     <= es_bus.ds_to_es_rt_value;
            dest_p1         <= es_bus.ds_to_es_dest;
            gr_we_p1        <= es_bus.ds_to_es_gr_we;
            mem_we_p1       <= es_bus.ds_to_es_mem_we;
            res_from_mem_p1 <= es_bus.ds_to_es_res_from_mem;
        end
    end

    // Operand select from the held instruction, first matching flag wins.
    always_comb begin
        imm_ext = imm_zext_p1 ? {{(DATA_W-16){1'b0}}, imm_p1}
                              : {{(DATA_W-16){imm_p1[15]}}, imm_p1};
        if (src1_is_sa_p1)       src1 = {{(DATA_W-5){1'b0}}, imm_p1[10:6]};
        else if (src1_is_pc_p1)  src1 = pc_p1;
        else                     src1 = rs_value_p1;
        if (src2_is_imm_p1)      src2 = imm_ext;
        else if (src2_is_8_p1)   src2 = DATA_W'(8);
        else                     src2 = rt_value_p1;
    end

    assign alu_result = alu_calc(alu_op_p1, src1, src2);

    assign es_bus.es_allowin            = es_allowin;
    assign es_bus.es_to_ms_valid        = vld_p1 & es_ready_go;
    assign es_bus.es_to_ms_pc           = pc_p1;
    assign es_bus.es_to_ms_alu_result   = alu_result;
    assign es_bus.es_to_ms_store_data   = rt_value_p1;
    assign es_bus.es_to_ms_dest         = dest_p1;
    assign es_bus.es_to_ms_gr_we        = gr_we_p1;
    assign es_bus.es_to_ms_mem_we       = mem_we_p1;
    assign es_bus.es_to_ms_res_from_mem = res_from_mem_p1;

    // bypass: $0 writes are never forwarded; loads force decode to stall
    assign es_bus.es_fwd_valid   = vld_p1 & gr_we_p1 & (dest_p1 != 5'd0);
    assign es_bus.es_fwd_dest    = dest_p1;
    assign es_bus.es_fwd_data    = alu_result;
    assign es_bus.es_fwd_is_load = vld_p1 & res_from_mem_p1;
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios plus randomized traffic, every
// cycle compared against a behavioural model of the stage.
module tb_ex_stage;
    typedef struct packed {
        logic [31:0] pc;
        logic [11:0] op;
        logic        sa;
        logic        is_pc;
        logic        is_imm;
        logic        is8;
        logic        zext;
        logic [15:0] imm;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [4:0]  dest;
        logic        gr_we;
        logic        mem_we;
        logic        rfm;
    } instr_t;

    logic   clk    = 1'b0;
    logic   resetn = 1'b0;
    logic   flush  = 1'b0;
    logic   cur_v  = 1'b0;
    logic   ms_al  = 1'b1;
    instr_t cur    = '0;

    int checks = 0;
    int errors = 0;

    // model state: held instruction and its valid bit
    logic   m_v = 1'b0;
    instr_t m_h = '0;

    always #5 clk = ~clk;

    ex_stage_if bus ();

    ex_stage dut (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .es_bus (bus)
    );

    assign bus.ds_to_es_valid        = cur_v;
    assign bus.ds_to_es_pc           = cur.pc;
    assign bus.ds_to_es_alu_op       = cur.op;
    assign bus.ds_to_es_src1_is_sa   = cur.sa;
    assign bus.ds_to_es_src1_is_pc   = cur.is_pc;
    assign bus.ds_to_es_src2_is_imm  = cur.is_imm;
    assign bus.ds_to_es_src2_is_8    = cur.is8;
    assign bus.ds_to_es_imm_zext     = cur.zext;
    assign bus.ds_to_es_imm          = cur.imm;
    assign bus.ds_to_es_rs_value     = cur.rs;
    assign bus.ds_to_es_rt_value     = cur.rt;
    assign bus.ds_to_es_dest         = cur.dest;
    assign bus.ds_to_es_gr_we        = cur.gr_we;
    assign bus.ds_to_es_mem_we       = cur.mem_we;
    assign bus.ds_to_es_res_from_mem = cur.rfm;
    assign bus.ms_allowin            = ms_al;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference ALU: operands picked by priority, result by operation name
    function automatic logic [31:0] ref_alu(input instr_t i);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] immx;
        immx = i.zext ? {16'h0000, i.imm} : {{16{i.imm[15]}}, i.imm};
        a = i.sa ? {27'd0, i.imm[10:6]} : (i.is_pc ? i.pc : i.rs);
        b = i.is_imm ? immx : (i.is8 ? 32'd8 : i.rt);
        case (i.op)
            12'h800: return a + b;
            12'h400: return a - b;
            12'h200: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            12'h100: return (a < b) ? 32'd1 : 32'd0;
            12'h080: return a & b;
            12'h040: return ~(a | b);
            12'h020: return a | b;
            12'h010: return a ^ b;
            12'h008: return b << a[4:0];
            12'h004: return b >> a[4:0];
            12'h002: return $signed(b) >>> a[4:0];
            12'h001: return {b[15:0], 16'h0000};
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_all();
        logic [31:0] r;
        r = ref_alu(m_h);
        chk("allowin",     {31'd0, bus.es_allowin},            {31'd0, (!m_v || ms_al)});
        chk("to_ms_valid", {31'd0, bus.es_to_ms_valid},        {31'd0, m_v});
        chk("pc",          bus.es_to_ms_pc,                    m_h.pc);
        chk("result",      bus.es_to_ms_alu_result,            r);
        chk("store_data",  bus.es_to_ms_store_data,            m_h.rt);
        chk("dest",        {27'd0, bus.es_to_ms_dest},         {27'd0, m_h.dest});
        chk("gr_we",       {31'd0, bus.es_to_ms_gr_we},        {31'd0, m_h.gr_we});
        chk("mem_we",      {31'd0, bus.es_to_ms_mem_we},       {31'd0, m_h.mem_we});
        chk("res_from_mem",{31'd0, bus.es_to_ms_res_from_mem}, {31'd0, m_h.rfm});
        chk("fwd_valid",   {31'd0, bus.es_fwd_valid},
            {31'd0, (m_v && m_h.gr_we && m_h.dest != 5'd0)});
        chk("fwd_dest",    {27'd0, bus.es_fwd_dest},           {27'd0, m_h.dest});
        chk("fwd_data",    bus.es_fwd_data,                    r);
        chk("fwd_is_load", {31'd0, bus.es_fwd_is_load},        {31'd0, (m_v && m_h.rfm)});
    endtask

    // stage behaviour at a clock edge
    task automatic model_edge();
        if (flush) begin
            m_v = 1'b0;
        end else if (!m_v || ms_al) begin
            if (cur_v) m_h = cur;
            m_v = cur_v;
        end
    endtask

    // inputs already driven: settle, compare, clock, advance model
    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic offer(input logic [11:0] op, input logic [31:0] rs, input logic [31:0] rt);
        cur       = '0;
        cur.op    = op;
        cur.rs    = rs;
        cur.rt    = rt;
        cur.dest  = 5'd2;
        cur.gr_we = 1'b1;
        cur.pc    = 32'hBFC0_0100;
        cur_v     = 1'b1;
    endtask

    initial begin
        int k;
        // reset state
        #12;
        check_all();
        chk("rst_allowin", {31'd0, bus.es_allowin}, 32'd1);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // add wraps to 0x80000000
        offer(12'h800, 32'h7FFF_FFFF, 32'd1);
        ms_al = 1'b1;
        step();
        cur_v = 1'b0;
        chk("add_vld", {31'd0, bus.es_to_ms_valid}, 32'd1);
        chk("add_res", bus.es_to_ms_alu_result, 32'h8000_0000);

        // sub held under backpressure while slt waits
        offer(12'h400, 32'd5, 32'd7);
        step();
        ms_al = 1'b0;
        offer(12'h200, 32'd1, 32'd2);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("sub_hold_res", bus.es_to_ms_alu_result, 32'hFFFF_FFFE);
            chk("sub_hold_allowin", {31'd0, bus.es_allowin}, 32'd0);
        end
        ms_al = 1'b1;
        step();
        cur_v = 1'b0;
        chk("slt_taken", bus.es_to_ms_alu_result, 32'd1);

        // operand selection
        offer(12'h800, 32'd1, 32'd0);
        cur.is_imm = 1'b1; cur.imm = 16'hFFFF;
        step();
        chk("addiu_sext", bus.es_to_ms_alu_result, 32'h0000_0000);
        offer(12'h020, 32'd0, 32'd0);
        cur.is_imm = 1'b1; cur.zext = 1'b1; cur.imm = 16'hFFFF;
        step();
        chk("ori_zext", bus.es_to_ms_alu_result, 32'h0000_FFFF);
        offer(12'h008, 32'hDEAD_BEEF, 32'd1);
        cur.sa = 1'b1; cur.imm = 16'h0100;
        step();
        chk("sll_sa", bus.es_to_ms_alu_result, 32'h0000_0010);
        offer(12'h800, 32'h1234_5678, 32'h0BAD_F00D);
        cur.is_pc = 1'b1; cur.is8 = 1'b1; cur.pc = 32'hBFC0_0000; cur.dest = 5'd31;
        step();
        chk("link_pc8", bus.es_to_ms_alu_result, 32'hBFC0_0008);

        // flush beats a simultaneous offer, next offer accepted
        offer(12'h800, 32'd10, 32'd20);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_kill", {31'd0, bus.es_to_ms_valid}, 32'd0);
        offer(12'h800, 32'd3, 32'd4);
        step();
        cur_v = 1'b0;
        chk("post_flush_vld", {31'd0, bus.es_to_ms_valid}, 32'd1);
        chk("post_flush_res", bus.es_to_ms_alu_result, 32'd7);

        // bypass
        offer(12'h800, 32'd1, 32'd1);
        cur.dest = 5'd0;
        step();
        chk("fwd_dest0", {31'd0, bus.es_fwd_valid}, 32'd0);
        offer(12'h800, 32'h1000_0000, 32'd0);
        cur.is_imm = 1'b1; cur.imm = 16'h0010; cur.dest = 5'd3; cur.rfm = 1'b1;
        step();
        cur_v = 1'b0;
        chk("load_fwd_vld", {31'd0, bus.es_fwd_valid}, 32'd1);
        chk("load_is_load", {31'd0, bus.es_fwd_is_load}, 32'd1);
        chk("load_fwd_dest", {27'd0, bus.es_fwd_dest}, 32'd3);

        // flush while MEM stalled drops the held load
        ms_al = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_stall", {31'd0, bus.es_to_ms_valid}, 32'd0);
        ms_al = 1'b1;

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            cur.pc     = $urandom;
            cur.rs     = $urandom;
            cur.rt     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            cur.imm    = 16'($urandom);
            cur.sa     = ($urandom_range(0, 3) == 0);
            cur.is_pc  = ($urandom_range(0, 3) == 0);
            cur.is_imm = ($urandom_range(0, 2) == 0);
            cur.is8    = ($urandom_range(0, 3) == 0);
            cur.zext   = 1'($urandom);
            cur.dest   = 5'($urandom);
            cur.gr_we  = 1'($urandom);
            cur.mem_we = 1'($urandom);
            cur.rfm    = 1'($urandom);
            k = $urandom_range(0, 12);
            cur.op = '0;
            if (k < 12) cur.op[k] = 1'b1;
            cur_v = ($urandom_range(0, 3) != 0);
            ms_al = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 9) == 0);
            step();
        end
        flush = 1'b0;

        // asynchronous reset while EX holds a live instruction
        offer(12'h800, 32'd9, 32'd9);
        cur.dest = 5'd7;
        ms_al = 1'b1;
        step();
        cur_v = 1'b0;
        ms_al = 1'b0;
        chk("pre_rst_fwd", {31'd0, bus.es_fwd_valid}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_to_ms_valid", {31'd0, bus.es_to_ms_valid}, 32'd0);
        chk("rst_fwd_valid", {31'd0, bus.es_fwd_valid}, 32'd0);
        chk("rst_allowin2", {31'd0, bus.es_allowin}, 32'd1);
        chk("rst_result", bus.es_to_ms_alu_result, 32'd0);
        m_v = 1'b0;
        m_h = '0;
        @(posedge clk);
        #2;
        resetn = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
